// File: rtl/ac_controller_param.sv
// ---------------------------------------------------------------------------
// ac_controller_param
//   Single-zone thermostat with hysteresis: IDLE / HEATING / COOLING.
//   Thresholds and temperature width are parameters. An operating mode
//   restricts which drives may run. A minimum-dwell timer protects the
//   compressor by blocking back-to-back state changes.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous reset, active-high
//   temperature   in   [WIDTH-1:0] unsigned temperature sample
//   temp_valid    in   sample qualifier; transitions only on valid samples
//   mode          in   [1:0] 00 OFF, 01 AUTO, 10 HEAT_ONLY, 11 COOL_ONLY
//   heating       out  heater drive (registered)
//   cooling       out  cooler drive (registered)
//   state         out  [1:0] 00 IDLE, 01 HEATING, 10 COOLING
//   dwell_active  out  high while the dwell counter is non-zero
// ---------------------------------------------------------------------------
module ac_controller_param #(
  parameter int WIDTH     = 5,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int COOL_OFF  = 20,
  parameter int COOL_ON   = 22,
  parameter int MIN_DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] temperature,
  input  logic             temp_valid,
  input  logic [1:0]       mode,
  output logic             heating,
  output logic             cooling,
  output logic [1:0]       state,
  output logic             dwell_active
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAT = 2'b01,
    ST_COOL = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'b00,
    MODE_AUTO      = 2'b01,
    MODE_HEAT_ONLY = 2'b10,
    MODE_COOL_ONLY = 2'b11
  } mode_e;

  // A counter that only ever holds MIN_DWELL-1 needs clog2(MIN_DWELL) bits;
  // keep at least one bit so MIN_DWELL=1 still elaborates (it just stays 0).
  localparam int CW = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;

  localparam logic [CW-1:0]    DWELL_LOAD = CW'(MIN_DWELL - 1);
  localparam logic [WIDTH-1:0] HEAT_ON_T  = WIDTH'(HEAT_ON);
  localparam logic [WIDTH-1:0] HEAT_OFF_T = WIDTH'(HEAT_OFF);
  localparam logic [WIDTH-1:0] COOL_OFF_T = WIDTH'(COOL_OFF);
  localparam logic [WIDTH-1:0] COOL_ON_T  = WIDTH'(COOL_ON);

  state_e        state_q, state_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic          heating_q, heating_d;
  logic          cooling_q, cooling_d;
  logic          dwell_active_q, dwell_active_d;
  logic          heat_ok, cool_ok;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    dwell_d = dwell_q;
    heat_ok = (mode == MODE_AUTO) || (mode == MODE_HEAT_ONLY);
    cool_ok = (mode == MODE_AUTO) || (mode == MODE_COOL_ONLY);

    if (mode == MODE_OFF) begin
      // OFF bypasses both the sample qualifier and the dwell timer.
      state_d = ST_IDLE;
    end else if (temp_valid && (dwell_q == '0)) begin
      unique case (state_q)
        ST_IDLE: begin
          // Heating is checked first; legal thresholds keep the two apart.
          if (heat_ok && (temperature <= HEAT_ON_T))      state_d = ST_HEAT;
          else if (cool_ok && (temperature >= COOL_ON_T)) state_d = ST_COOL;
        end
        ST_HEAT: if (!heat_ok || (temperature >= HEAT_OFF_T)) state_d = ST_IDLE;
        ST_COOL: if (!cool_ok || (temperature <= COOL_OFF_T)) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Any change of state (forced OFF exits included) restarts the dwell.
    if (state_d != state_q)  dwell_d = DWELL_LOAD;
    else if (dwell_q != '0)  dwell_d = dwell_q - CW'(1);

    heating_d      = (state_d == ST_HEAT);
    cooling_d      = (state_d == ST_COOL);
    dwell_active_d = (dwell_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      dwell_q        <= '0;
      heating_q      <= 1'b0;
      cooling_q      <= 1'b0;
      dwell_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dwell_q        <= dwell_d;
      heating_q      <= heating_d;
      cooling_q      <= cooling_d;
      dwell_active_q <= dwell_active_d;
    end
  end

  assign heating      = heating_q;
  assign cooling      = cooling_q;
  assign state        = state_q;
  assign dwell_active = dwell_active_q;

endmodule

// File: tb/tb_ac_controller_param.sv
// ---------------------------------------------------------------------------
// tb_ac_controller_param
//   Table-driven bench for ac_controller_param with default parameters.
//   Each vector row holds the inputs for one clock edge and the outputs
//   expected right after that edge. Expected outputs are queued when the
//   inputs are driven and popped for comparison after the edge.
// ---------------------------------------------------------------------------
module tb_ac_controller_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] temperature = '0;
  logic       temp_valid = 1'b0;
  logic [1:0] mode = 2'b01;
  logic       heating, cooling, dwell_active;
  logic [1:0] state;

  localparam logic [1:0] M_OFF = 2'b00, M_AUTO = 2'b01, M_COOL = 2'b11;
  localparam logic [1:0] S_IDLE = 2'b00, S_HEAT = 2'b01, S_COOL = 2'b10;

  ac_controller_param dut (
    .clk          (clk),
    .rst          (rst),
    .temperature  (temperature),
    .temp_valid   (temp_valid),
    .mode         (mode),
    .heating      (heating),
    .cooling      (cooling),
    .state        (state),
    .dwell_active (dwell_active)
  );

  always #5 clk = ~clk;

  // Expected output word: {heating, cooling, state[1:0], dwell_active}
  typedef struct {
    string      name;
    logic       rst;
    int         temp;
    logic       valid;
    logic [1:0] mode;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(string n, logic r, int t, logic v, logic [1:0] m,
                              logic h, logic c, logic [1:0] s, logic d);
    vec_t x;
    x.name = n; x.rst = r; x.temp = t; x.valid = v; x.mode = m;
    x.exp = {h, c, s, d};
    return x;
  endfunction

  task automatic check(string name, logic [4:0] act, logic [4:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {h,c,st,dw}=%b required %b", name, act, exp);
  endtask

  // Drive one vector half a cycle before the edge, compare 1 ns after it.
  task automatic step(vec_t v);
    sb_t e;
    @(negedge clk);
    rst = v.rst; temperature = 5'(v.temp); temp_valid = v.valid; mode = v.mode;
    sb_q.push_back('{v.name, v.exp});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(e.name, {heating, cooling, state, dwell_active}, e.exp);
  endtask

  initial begin : main
    int dw_cycles;

    vecs.push_back(mk("reset",          1, 20, 0, M_AUTO, 0,0,S_IDLE,0));
    vecs.push_back(mk("heat_enter_15",  0, 15, 1, M_AUTO, 1,0,S_HEAT,1));
    vecs.push_back(mk("heat_dwell_a",   0, 15, 1, M_AUTO, 1,0,S_HEAT,1));
    vecs.push_back(mk("heat_dwell_b",   0, 15, 1, M_AUTO, 1,0,S_HEAT,1));
    vecs.push_back(mk("heat_dwell_end", 0, 15, 1, M_AUTO, 1,0,S_HEAT,0));
    for (int t = 16; t <= 19; t++)
      vecs.push_back(mk($sformatf("sweep_up_%0d", t), 0, t, 1, M_AUTO, 1,0,S_HEAT,0));
    vecs.push_back(mk("heat_off_20",    0, 20, 1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("idle_21_a",      0, 21, 1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("idle_21_b",      0, 21, 1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("idle_21_c",      0, 21, 1, M_AUTO, 0,0,S_IDLE,0));
    vecs.push_back(mk("cool_on_22",     0, 22, 1, M_AUTO, 0,1,S_COOL,1));
    vecs.push_back(mk("cool_22_a",      0, 22, 1, M_AUTO, 0,1,S_COOL,1));
    vecs.push_back(mk("cool_22_b",      0, 22, 1, M_AUTO, 0,1,S_COOL,1));
    vecs.push_back(mk("cool_22_c",      0, 22, 1, M_AUTO, 0,1,S_COOL,0));
    vecs.push_back(mk("cool_hold_21",   0, 21, 1, M_AUTO, 0,1,S_COOL,0));
    vecs.push_back(mk("cool_off_20",    0, 20, 1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("settle_a",       0, 21, 1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("settle_b",       0, 21, 1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("settle_c",       0, 21, 1, M_AUTO, 0,0,S_IDLE,0));
    // Dwell: jump from 15 straight to 25.
    vecs.push_back(mk("dw_heat_enter",  0, 15, 1, M_AUTO, 1,0,S_HEAT,1));
    vecs.push_back(mk("dw_heat_2",      0, 25, 1, M_AUTO, 1,0,S_HEAT,1));
    vecs.push_back(mk("dw_heat_3",      0, 25, 1, M_AUTO, 1,0,S_HEAT,1));
    vecs.push_back(mk("dw_heat_4",      0, 25, 1, M_AUTO, 1,0,S_HEAT,0));
    vecs.push_back(mk("dw_idle_5",      0, 25, 1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("dw_idle_6",      0, 25, 1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("dw_idle_7",      0, 25, 1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("dw_idle_8",      0, 25, 1, M_AUTO, 0,0,S_IDLE,0));
    vecs.push_back(mk("dw_cool_9",      0, 25, 1, M_AUTO, 0,1,S_COOL,1));
    // OFF override while the dwell counter is loaded.
    vecs.push_back(mk("off_force",      0, 25, 1, M_OFF,  0,0,S_IDLE,1));
    vecs.push_back(mk("off_dwell_a",    0, 25, 1, M_OFF,  0,0,S_IDLE,1));
    vecs.push_back(mk("off_dwell_b",    0, 25, 1, M_OFF,  0,0,S_IDLE,1));
    vecs.push_back(mk("off_dwell_c",    0, 25, 1, M_OFF,  0,0,S_IDLE,0));
    // Mode restriction.
    vecs.push_back(mk("coolonly_cold_a",0, 10, 1, M_COOL, 0,0,S_IDLE,0));
    vecs.push_back(mk("coolonly_cold_b",0, 10, 1, M_COOL, 0,0,S_IDLE,0));
    vecs.push_back(mk("auto_cold_heat", 0, 10, 1, M_AUTO, 1,0,S_HEAT,1));
    // Reset mid-operation.
    vecs.push_back(mk("reset_mid_heat", 1, 10, 1, M_AUTO, 0,0,S_IDLE,0));
    // temp_valid gating.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk($sformatf("invalid_hold_%0d", i), 0, 10, 0, M_AUTO, 0,0,S_IDLE,0));
    vecs.push_back(mk("valid_heat",     0, 10, 1, M_AUTO, 1,0,S_HEAT,1));
    // Disallowing mode waits for the dwell to expire.
    vecs.push_back(mk("modechg_wait_a", 0, 10, 1, M_COOL, 1,0,S_HEAT,1));
    vecs.push_back(mk("modechg_wait_b", 0, 10, 1, M_COOL, 1,0,S_HEAT,1));
    vecs.push_back(mk("modechg_wait_c", 0, 10, 1, M_COOL, 1,0,S_HEAT,0));
    vecs.push_back(mk("modechg_exit",   0, 10, 1, M_COOL, 0,0,S_IDLE,1));
    // Extreme sample values 31 and 0.
    vecs.push_back(mk("max_wait_a",     0, 31, 1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("max_wait_b",     0, 31, 1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("max_wait_c",     0, 31, 1, M_AUTO, 0,0,S_IDLE,0));
    vecs.push_back(mk("max_cool",       0, 31, 1, M_AUTO, 0,1,S_COOL,1));
    vecs.push_back(mk("zero_cool_a",    0, 0,  1, M_AUTO, 0,1,S_COOL,1));
    vecs.push_back(mk("zero_cool_b",    0, 0,  1, M_AUTO, 0,1,S_COOL,1));
    vecs.push_back(mk("zero_cool_c",    0, 0,  1, M_AUTO, 0,1,S_COOL,0));
    vecs.push_back(mk("zero_idle",      0, 0,  1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("zero_wait_a",    0, 0,  1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("zero_wait_b",    0, 0,  1, M_AUTO, 0,0,S_IDLE,1));
    vecs.push_back(mk("zero_wait_c",    0, 0,  1, M_AUTO, 0,0,S_IDLE,0));
    vecs.push_back(mk("zero_heat",      0, 0,  1, M_AUTO, 1,0,S_HEAT,1));

    foreach (vecs[i]) step(vecs[i]);

    // Hand-written: OFF while heating with a fresh dwell, then measure how
    // long dwell_active stays high afterwards (bounded wait).
    step(mk("off_from_heat", 0, 0, 1, M_OFF, 0,0,S_IDLE,1));
    dw_cycles = 0;
    for (int i = 0; i < 10 && dwell_active; i++) begin
      @(posedge clk);
      #1;
      if (dwell_active) dw_cycles++;
    end
    check("off_dwell_timeout", {4'b0, dwell_active}, 5'b0);
    check("off_dwell_len", 5'(dw_cycles), 5'd2);

    // Hand-written: with mode OFF and a cold valid sample, IDLE is kept.
    step(mk("off_idle_stays", 0, 3, 1, M_OFF, 0,0,S_IDLE,0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
